alu_share_arbiter: RTL and testbench

- Time-multiplexes one combinational ALU (4-bit op select, LEN-bit operands, zero flag) between two requesters, e.g. the main execute path (r0) and an address-generation or branch-target helper (r1).
- Round-robin arbitration, registered operands, registered result.
- Valid/ready handshake on both the request and the response side.
- Sits between the requesters and the ALU instance; owns the ALU's inputs exclusively.

---
 rtl/alu_share_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional saturating performance counters are enabled with `define ALU_ARB_PERF_EN.
module alu_share_arbiter #(
    parameter int LEN  = 32,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            r0_req_valid,
    output logic            r0_req_ready,
    input  logic [LEN-1:0]  r0_op1,
    input  logic [LEN-1:0]  r0_op2,
    input  logic [3:0]      r0_ctrl,
    input  logic [TAGW-1:0] r0_tag,
    output logic            r0_resp_valid,
    input  logic            r0_resp_ready,
    output logic [LEN-1:0]  r0_result,
    output logic            r0_zero,
    output logic [TAGW-1:0] r0_resp_tag,

    input  logic            r1_req_valid,
    output logic            r1_req_ready,
    input  logic [LEN-1:0]  r1_op1,
    input  logic [LEN-1:0]  r1_op2,
    input  logic [3:0]      r1_ctrl,
    input  logic [TAGW-1:0] r1_tag,
    output logic            r1_resp_valid,
    input  logic            r1_resp_ready,
    output logic [LEN-1:0]  r1_result,
    output logic            r1_zero,
    output logic [TAGW-1:0] r1_resp_tag,

    output logic [LEN-1:0]  alu_op1,
    output logic [LEN-1:0]  alu_op2,
    output logic [3:0]      alu_ctrl,
    input  logic [LEN-1:0]  alu_result,
    input  logic            alu_zero
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]     perf_grant0,
    output logic [31:0]     perf_grant1,
    output logic [31:0]     perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state, state_nx;
    logic            rr;
    logic            gnt_any;
    logic            gnt_id;
    logic            accept;
    logic            resp_ready_sel;

    logic [LEN-1:0]  op1_q, op2_q;
    logic [3:0]      ctrl_q;
    logic [TAGW-1:0] tag_q;
    logic            id_q;

    logic [LEN-1:0]  res0_q, res1_q;
    logic            zero0_q, zero1_q;
    logic [TAGW-1:0] rtag0_q, rtag1_q;

    // rr only matters under contention; a lone requester always wins.
    always_comb begin
        gnt_any = r0_req_valid | r1_req_valid;
        if (r0_req_valid && r1_req_valid) begin
            gnt_id = rr;
        end else begin
            gnt_id = r1_req_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        r0_req_ready   = 1'b0;
        r1_req_ready   = 1'b0;
        r0_resp_valid  = 1'b0;
        r1_resp_valid  = 1'b0;
        resp_ready_sel = 1'b0;
        case (state)
            IDLE: begin
                // ready is masked while rst is high so nothing looks accepted during reset
                if (!rst) begin
                    r0_req_ready = gnt_any && !gnt_id;
                    r1_req_ready = gnt_any &&  gnt_id;
                end
                if (gnt_any) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                state_nx = RESP;
            end
            RESP: begin
                r0_resp_valid  = !id_q;
                r1_resp_valid  =  id_q;
                resp_ready_sel = id_q ? r1_resp_ready : r0_resp_ready;
                if (resp_ready_sel) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign accept = (r0_req_valid && r0_req_ready) || (r1_req_valid && r1_req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr      <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            ctrl_q  <= '0;
            tag_q   <= '0;
            id_q    <= 1'b0;
            res0_q  <= '0;
            res1_q  <= '0;
            zero0_q <= 1'b0;
            zero1_q <= 1'b0;
            rtag0_q <= '0;
            rtag1_q <= '0;
        end else begin
            if (accept) begin
                op1_q  <= gnt_id ? r1_op1  : r0_op1;
                op2_q  <= gnt_id ? r1_op2  : r0_op2;
                ctrl_q <= gnt_id ? r1_ctrl : r0_ctrl;
                tag_q  <= gnt_id ? r1_tag  : r0_tag;
                id_q   <= gnt_id;
                rr     <= !gnt_id;
            end
            // Per-requester result registers keep the idle side's last response intact.
            if (state == EXEC) begin
                if (id_q) begin
                    res1_q  <= alu_result;
                    zero1_q <= alu_zero;
                    rtag1_q <= tag_q;
                end else begin
                    res0_q  <= alu_result;
                    zero0_q <= alu_zero;
                    rtag0_q <= tag_q;
                end
            end
        end
    end

    assign alu_op1     = op1_q;
    assign alu_op2     = op2_q;
    assign alu_ctrl    = ctrl_q;

    assign r0_result   = res0_q;
    assign r0_zero     = zero0_q;
    assign r0_resp_tag = rtag0_q;
    assign r1_result   = res1_q;
    assign r1_zero     = zero1_q;
    assign r1_resp_tag = rtag1_q;

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall  <= '0;
        end else begin
            if (accept && !gnt_id && perf_grant0 != '1) begin
                perf_grant0 <= perf_grant0 + 32'd1;
            end
            if (accept && gnt_id && perf_grant1 != '1) begin
                perf_grant1 <= perf_grant1 + 32'd1;
            end
            if (state == RESP && !resp_ready_sel && perf_stall != '1) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a small reference ALU.
module tb_alu_share_arbiter;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b1011;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req_valid, r0_req_ready, r0_resp_valid, r0_resp_ready, r0_zero;
    logic [31:0] r0_op1, r0_op2, r0_result;
    logic [3:0]  r0_ctrl, r0_tag, r0_resp_tag;
    logic        r1_req_valid, r1_req_ready, r1_resp_valid, r1_resp_ready, r1_zero;
    logic [31:0] r1_op1, r1_op2, r1_result;
    logic [3:0]  r1_ctrl, r1_tag, r1_resp_tag;
    logic [31:0] alu_op1, alu_op2, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;
`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_stall;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.LEN(32), .TAGW(4)) dut (
        .clk(clk), .rst(rst),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
        .r0_op1(r0_op1), .r0_op2(r0_op2), .r0_ctrl(r0_ctrl), .r0_tag(r0_tag),
        .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready),
        .r0_result(r0_result), .r0_zero(r0_zero), .r0_resp_tag(r0_resp_tag),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
        .r1_op1(r1_op1), .r1_op2(r1_op2), .r1_ctrl(r1_ctrl), .r1_tag(r1_tag),
        .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready),
        .r1_result(r1_result), .r1_zero(r1_zero), .r1_resp_tag(r1_resp_tag),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
    );

    // Reference ALU; codes outside this set return 0 (zero=1).
    always_comb begin
        case (alu_ctrl)
            OP_ADD:  alu_result = alu_op1 + alu_op2;
            OP_SUB:  alu_result = alu_op1 - alu_op2;
            OP_AND:  alu_result = alu_op1 & alu_op2;
            OP_OR:   alu_result = alu_op1 | alu_op2;
            OP_XOR:  alu_result = alu_op1 ^ alu_op2;
            OP_SRA:  alu_result = 32'($signed(alu_op1) >>> alu_op2[4:0]);
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct {
        bit          rq;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  ctrl;
        logic [3:0]  tag;
        logic [31:0] res;
        bit          zero;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic req_rdy(input bit n);
        return n ? r1_req_ready : r0_req_ready;
    endfunction
    function automatic logic resp_vld(input bit n);
        return n ? r1_resp_valid : r0_resp_valid;
    endfunction
    function automatic logic [31:0] res_of(input bit n);
        return n ? r1_result : r0_result;
    endfunction
    function automatic logic zero_of(input bit n);
        return n ? r1_zero : r0_zero;
    endfunction
    function automatic logic [3:0] rtag_of(input bit n);
        return n ? r1_resp_tag : r0_resp_tag;
    endfunction

    task automatic set_req(input bit n, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c, input logic [3:0] t);
        if (n) begin
            r1_req_valid = v; r1_op1 = a; r1_op2 = b; r1_ctrl = c; r1_tag = t;
        end else begin
            r0_req_valid = v; r0_op1 = a; r0_op2 = b; r0_ctrl = c; r0_tag = t;
        end
    endtask

    task automatic set_rr(input bit n, input logic v);
        if (n) r1_resp_ready = v;
        else   r0_resp_ready = v;
    endtask

    // One isolated transaction: handshake, EXEC, RESP two cycles later, then release.
    task automatic run_one(input vec_t v);
        @(negedge clk);
        set_req(v.rq, 1'b1, v.op1, v.op2, v.ctrl, v.tag);
        #1 chk("req_ready", {63'd0, req_rdy(v.rq)}, 64'd1);
        chk("other_req_ready", {63'd0, req_rdy(!v.rq)}, 64'd0);
        @(negedge clk);
        set_req(v.rq, 1'b0, ~v.op1, ~v.op2, ~v.ctrl, ~v.tag);
        #1 chk("exec_resp_valid", {63'd0, resp_vld(v.rq)}, 64'd0);
        chk("exec_alu_op1", {32'd0, alu_op1}, {32'd0, v.op1});
        chk("exec_alu_ctrl", {60'd0, alu_ctrl}, {60'd0, v.ctrl});
        @(negedge clk);
        #1 chk("resp_valid", {63'd0, resp_vld(v.rq)}, 64'd1);
        chk("other_resp_valid", {63'd0, resp_vld(!v.rq)}, 64'd0);
        chk("result", {32'd0, res_of(v.rq)}, {32'd0, v.res});
        chk("zero", {63'd0, zero_of(v.rq)}, {63'd0, v.zero});
        chk("resp_tag", {60'd0, rtag_of(v.rq)}, {60'd0, v.tag});
        set_rr(v.rq, 1'b1);
        @(negedge clk);
        set_rr(v.rq, 1'b0);
        #1 chk("resp_valid_after_hs", {63'd0, resp_vld(v.rq)}, 64'd0);
        chk("result_held", {32'd0, res_of(v.rq)}, {32'd0, v.res});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants[$];
        int n0, n1, k0, k1, stall_left;

        vecs[0] = '{1'b0, 32'd5, 32'd7, OP_ADD, 4'd3, 32'd12, 1'b0};
        vecs[1] = '{1'b1, 32'd9, 32'd9, OP_SUB, 4'd5, 32'd0, 1'b1};
        vecs[2] = '{1'b1, 32'h8000_0000, 32'd4, OP_SRA, 4'd6, 32'hF800_0000, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_F0F0, 32'h0000_0FF0, OP_AND, 4'd1, 32'h0000_00F0, 1'b0};
        vecs[4] = '{1'b0, 32'd1, 32'd2, 4'b1111, 4'd7, 32'd0, 1'b1};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'd1, OP_ADD, 4'hF, 32'd0, 1'b1};
        vecs[6] = '{1'b0, 32'hAAAA_5555, 32'h5555_AAAA, OP_XOR, 4'h2, 32'hFFFF_FFFF, 1'b0};

        rst = 1'b1;
        set_req(1'b0, 1'b1, 32'd1, 32'd1, OP_ADD, 4'd1);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, OP_ADD, 4'd0);
        r0_resp_ready = 1'b0;
        r1_resp_ready = 1'b0;

        // Reset state
        @(negedge clk);
        #1 chk("rst_r0_req_ready", {63'd0, r0_req_ready}, 64'd0);
        chk("rst_r0_resp_valid", {63'd0, r0_resp_valid}, 64'd0);
        chk("rst_r1_resp_valid", {63'd0, r1_resp_valid}, 64'd0);
        chk("rst_alu_op1", {32'd0, alu_op1}, 64'd0);
        chk("rst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
        chk("rst_r0_result", {32'd0, r0_result}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        r0_req_valid = 1'b0;

        for (int i = 0; i < 7; i++) run_one(vecs[i]);

        // Backpressure: r0 XOR held in RESP for 5 cycles while r1 waits.
        @(negedge clk);
        set_req(1'b0, 1'b1, 32'h0F0F_0F0F, 32'h00FF_00FF, OP_XOR, 4'hA);
        #1 chk("bp_r0_ready", {63'd0, r0_req_ready}, 64'd1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'd0, 32'd0, OP_ADD, 4'd0);
        set_req(1'b1, 1'b1, 32'h1234_5678, 32'hFF00_FF00, OP_AND, 4'hB);
        #1 chk("bp_r1_ready_exec", {63'd0, r1_req_ready}, 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1 chk("bp_resp_valid", {63'd0, r0_resp_valid}, 64'd1);
            chk("bp_result", {32'd0, r0_result}, 64'h0FF0_0FF0);
            chk("bp_tag", {60'd0, r0_resp_tag}, 64'hA);
            chk("bp_r1_ready", {63'd0, r1_req_ready}, 64'd0);
        end
        @(negedge clk);
        r0_resp_ready = 1'b1;
        #1 chk("bp_resp_valid_hs", {63'd0, r0_resp_valid}, 64'd1);
        chk("bp_r1_ready_hs", {63'd0, r1_req_ready}, 64'd0);
        @(negedge clk);
        r0_resp_ready = 1'b0;
        #1 chk("bp_r1_granted", {63'd0, r1_req_ready}, 64'd1);
        chk("bp_r0_resp_done", {63'd0, r0_resp_valid}, 64'd0);
        @(negedge clk);
        r1_req_valid = 1'b0;
        @(negedge clk);
        #1 chk("bp_r1_resp_valid", {63'd0, r1_resp_valid}, 64'd1);
        chk("bp_r1_result", {32'd0, r1_result}, 64'h1200_5600);
        chk("bp_r1_tag", {60'd0, r1_resp_tag}, 64'hB);
        r1_resp_ready = 1'b1;
        @(negedge clk);
        r1_resp_ready = 1'b0;

        // Reset pulsed while r1 AND is in EXEC: no response may appear.
        @(negedge clk);
        set_req(1'b1, 1'b1, 32'h0000_FFFF, 32'h0000_0F0F, OP_AND, 4'hC);
        #1 chk("rx_r1_ready", {63'd0, r1_req_ready}, 64'd1);
        @(negedge clk);
        r1_req_valid = 1'b0;
        #1 chk("rx_exec_ctrl", {60'd0, alu_ctrl}, {60'd0, OP_AND});
        rst = 1'b1;
        r0_req_valid = 1'b1;
        r1_req_valid = 1'b1;
        #1 chk("rx_r1_resp_valid", {63'd0, r1_resp_valid}, 64'd0);
        chk("rx_r0_req_ready", {63'd0, r0_req_ready}, 64'd0);
        chk("rx_r1_req_ready", {63'd0, r1_req_ready}, 64'd0);
        chk("rx_alu_op1", {32'd0, alu_op1}, 64'd0);
        chk("rx_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
        chk("rx_r0_result", {32'd0, r0_result}, 64'd0);
        chk("rx_r1_result", {32'd0, r1_result}, 64'd0);
        chk("rx_r1_tag", {60'd0, r1_resp_tag}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        r0_req_valid = 1'b0;
        r1_req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 chk("rx_no_resp", {62'd0, r1_resp_valid, r0_resp_valid}, 64'd0);
        end

        // Contention: both hold valid, 3 ops each; r0 stalls its first response for 2 cycles.
        n0 = 0; n1 = 0; k0 = 0; k1 = 0; stall_left = 2;
        for (int cyc = 0; cyc < 80 && (k0 < 3 || k1 < 3); cyc++) begin
            @(negedge clk);
            #1;
            if (r0_resp_valid) begin
                if (stall_left > 0) begin
                    r0_resp_ready = 1'b0;
                    stall_left--;
                end else begin
                    r0_resp_ready = 1'b1;
                    chk("ct_r0_tag", {60'd0, r0_resp_tag}, 64'(k0));
                    chk("ct_r0_result", {32'd0, r0_result}, 64'(100 + k0));
                    k0++;
                end
            end else begin
                r0_resp_ready = 1'b0;
            end
            if (r1_resp_valid) begin
                r1_resp_ready = 1'b1;
                chk("ct_r1_tag", {60'd0, r1_resp_tag}, 64'(8 + k1));
                chk("ct_r1_result", {32'd0, r1_result}, 64'(50 - k1));
                k1++;
            end else begin
                r1_resp_ready = 1'b0;
            end
            set_req(1'b0, n0 < 3, 32'd100, 32'(n0), OP_ADD, 4'(n0));
            set_req(1'b1, n1 < 3, 32'd50, 32'(n1), OP_SUB, 4'(8 + n1));
            #1;
            chk("ct_single_ready", {63'd0, r0_req_ready & r1_req_ready}, 64'd0);
            if (r0_req_valid && r0_req_ready) begin
                grants.push_back(0);
                n0++;
            end
            if (r1_req_valid && r1_req_ready) begin
                grants.push_back(1);
                n1++;
            end
        end
        @(negedge clk);
        r0_resp_ready = 1'b0;
        r1_resp_ready = 1'b0;
        set_req(1'b0, 1'b0, 32'd0, 32'd0, OP_ADD, 4'd0);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, OP_ADD, 4'd0);
        chk("ct_responses", 64'(k0 + k1), 64'd6);
        chk("ct_grant_count", 64'(grants.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk("ct_grant_order", (i < grants.size()) ? 64'(grants[i]) : 64'hFF, 64'(i % 2));
        end
`ifdef ALU_ARB_PERF_EN
        chk("perf_grant0", {32'd0, perf_grant0}, 64'd3);
        chk("perf_grant1", {32'd0, perf_grant1}, 64'd3);
        chk("perf_stall", {32'd0, perf_stall}, 64'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
